// File: rtl/scan_capture.sv
// Receive side of the 5x7 LED-matrix scan link: synchronises row/column lines,
// captures one column word per settled one-hot row and publishes whole 35-bit frames.
module scan_capture #(
    parameter int unsigned SETTLE      = 16,
    parameter int unsigned TIMEOUT     = 1_000_000,
    parameter bit          ROW_ACT_LOW = 1'b0,
    parameter bit          COL_ACT_LOW = 1'b0
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic [4:0]  row,
    input  logic [6:0]  column,
    output logic [34:0] ens_out,
    output logic        frame_valid,
    output logic        scan_active,
    output logic        row_err
);

    localparam int unsigned ROWS   = 5;
    localparam int unsigned COLS   = 7;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned STAB_W = $clog2(SETTLE + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ROWS-1:0]          r_row_s1;
    logic [ROWS-1:0]          r_row_s2;
    logic [COLS-1:0]          r_col_s1;
    logic [COLS-1:0]          r_col_s2;
    logic [ROWS-1:0]          r_cur;
    logic [ROWS-1:0]          w_cur_nxt;
    logic [STAB_W-1:0]        r_stab_cnt;
    logic [STAB_W-1:0]        w_stab_nxt;
    logic [IDLE_W-1:0]        r_idle_cnt;
    logic [ROWS-1:0]          r_seen;
    logic [COLS-1:0]          r_shadow [ROWS];
    logic                     r_multi_d;

    logic [ROWS-1:0]          w_rs;
    logic [COLS-1:0]          w_cs;
    logic [CNT_W-1:0]         w_ones;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_valid;
    logic                     w_multi;
    logic                     w_capture;
    logic [ROWS-1:0]          w_seen_upd;
    logic                     w_frame_done;
    logic                     w_timeout;
    logic [ROWS*COLS-1:0]     w_frame;

    // Two-flop synchronisers for the asynchronous scanner lines
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_row_s1 <= '0;
            r_row_s2 <= '0;
            r_col_s1 <= '0;
            r_col_s2 <= '0;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
            r_col_s1 <= column;
            r_col_s2 <= r_col_s1;
        end
    end

    assign w_rs = r_row_s2 ^ {ROWS{ROW_ACT_LOW}};
    assign w_cs = r_col_s2 ^ {COLS{COL_ACT_LOW}};

    // Row classification: population count and index of the (last) set bit
    always_comb begin
        w_ones = '0;
        w_idx  = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (w_rs[i]) begin
                w_ones = w_ones + CNT_W'(1);
                w_idx  = IDX_W'(i);
            end
        end
    end

    assign w_valid = (w_ones == CNT_W'(1));
    assign w_multi = (w_ones > CNT_W'(1));

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: settle count runs while the row is stable, one capture per dwell
    always_comb begin
        w_state_nxt = r_state;
        w_stab_nxt  = r_stab_cnt;
        w_cur_nxt   = r_cur;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_state_nxt = ST_SETTLE;
                    w_stab_nxt  = STAB_W'(1);
                    w_cur_nxt   = w_rs;
                end
            end
            ST_SETTLE: begin
                if (w_rs == r_cur) begin
                    if (r_stab_cnt == STAB_W'(SETTLE)) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_stab_nxt = r_stab_cnt + STAB_W'(1);
                    end
                end else if (w_valid) begin
                    w_state_nxt = ST_SETTLE;
                    w_stab_nxt  = STAB_W'(1);
                    w_cur_nxt   = w_rs;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (w_rs != r_cur) begin
                    if (w_valid) begin
                        w_state_nxt = ST_SETTLE;
                        w_stab_nxt  = STAB_W'(1);
                        w_cur_nxt   = w_rs;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame assembly including the capture being made this cycle
    always_comb begin
        w_seen_upd = r_seen;
        w_frame    = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (w_capture && (w_idx == IDX_W'(r))) begin
                w_seen_upd[r]            = 1'b1;
                w_frame[r*COLS +: COLS]  = w_cs;
            end else begin
                w_frame[r*COLS +: COLS]  = r_shadow[r];
            end
        end
    end

    assign w_frame_done = w_capture && (w_seen_upd == {ROWS{1'b1}});
    assign w_timeout    = (r_idle_cnt == IDLE_W'(TIMEOUT));

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_stab_cnt  <= '0;
            r_cur       <= '0;
            r_idle_cnt  <= '0;
            r_seen      <= '0;
            r_multi_d   <= 1'b0;
            ens_out     <= '0;
            frame_valid <= 1'b0;
            scan_active <= 1'b0;
            row_err     <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                r_shadow[r] <= '0;
            end
        end else begin
            r_stab_cnt  <= w_stab_nxt;
            r_cur       <= w_cur_nxt;
            r_multi_d   <= w_multi;
            row_err     <= w_multi & ~r_multi_d;
            frame_valid <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                if (w_capture && (w_idx == IDX_W'(r))) begin
                    r_shadow[r] <= w_cs;
                end
            end
            if (w_capture) begin
                r_idle_cnt <= '0;
            end else if (!w_timeout) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end
            // A capture always takes priority over the idle timeout
            if (w_frame_done) begin
                ens_out     <= w_frame;
                frame_valid <= 1'b1;
                scan_active <= 1'b1;
                r_seen      <= '0;
            end else if (w_capture) begin
                r_seen <= w_seen_upd;
            end else if (w_timeout) begin
                scan_active <= 1'b0;
                r_seen      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_scan_capture.sv
// Scoreboard bench for scan_capture: an active-high instance and an active-low
// instance fed the inverted copy of the same scan stimulus.
module tb_scan_capture;

    logic        clk;
    logic        rst_n;
    logic [4:0]  row;
    logic [6:0]  column;
    logic [4:0]  row_n;
    logic [6:0]  column_n;
    logic [34:0] ens_out;
    logic        frame_valid;
    logic        scan_active;
    logic        row_err;
    logic [34:0] ens_out_n;
    logic        frame_valid_n;
    logic        scan_active_n;
    logic        row_err_n;

    int          checks;
    int          errors;
    int          frames_seen;
    int          frames_seen_n;
    int          err_pulses;
    logic [34:0] exp_q[$];
    logic [34:0] exp_n_q[$];
    logic [34:0] last_frame;

    assign row_n    = ~row;
    assign column_n = ~column;

    scan_capture #(.SETTLE(16), .TIMEOUT(1000), .ROW_ACT_LOW(1'b0), .COL_ACT_LOW(1'b0)) u_dut (
        .CLOCK_50   (clk),
        .rst_n      (rst_n),
        .row        (row),
        .column     (column),
        .ens_out    (ens_out),
        .frame_valid(frame_valid),
        .scan_active(scan_active),
        .row_err    (row_err)
    );

    scan_capture #(.SETTLE(16), .TIMEOUT(1000), .ROW_ACT_LOW(1'b1), .COL_ACT_LOW(1'b1)) u_dut_n (
        .CLOCK_50   (clk),
        .rst_n      (rst_n),
        .row        (row_n),
        .column     (column_n),
        .ens_out    (ens_out_n),
        .frame_valid(frame_valid_n),
        .scan_active(scan_active_n),
        .row_err    (row_err_n)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitors: pop the expected frame whenever a DUT publishes one
    always @(negedge clk) begin
        if (frame_valid) begin
            frames_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_unexpected actual=%h required=none", ens_out);
            end else begin
                chk("frame", ens_out, exp_q.pop_front());
            end
        end
        if (row_err) err_pulses++;
    end

    always @(negedge clk) begin
        if (frame_valid_n) begin
            frames_seen_n++;
            if (exp_n_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_n_unexpected actual=%h required=none", ens_out_n);
            end else begin
                chk("frame_n", ens_out_n, exp_n_q.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan_row(input int r, input logic [6:0] cols, input int dwell);
        row    = 5'b00001 << r;
        column = cols;
        cycles(dwell);
    endtask

    task automatic expect_frame(input logic [34:0] f);
        exp_q.push_back(f);
        exp_n_q.push_back(f);
        last_frame = f;
    endtask

    task automatic scan_frame(input logic [34:0] f);
        logic [34:0] fr;
        fr = f;
        expect_frame(f);
        for (int r = 0; r < 5; r++) scan_row(r, fr[7*r +: 7], 100);
    endtask

    initial begin
        int fs;
        int ep;
        checks        = 0;
        errors        = 0;
        frames_seen   = 0;
        frames_seen_n = 0;
        err_pulses    = 0;
        last_frame    = '0;
        rst_n         = 1'b0;
        row           = '0;
        column        = '0;
        cycles(4);
        chk("rst_ens_out", ens_out, 35'h0);
        chk("rst_frame_valid", 35'(frame_valid), 35'h0);
        chk("rst_scan_active", 35'(scan_active), 35'h0);
        chk("rst_row_err", 35'(row_err), 35'h0);
        chk("rst_ens_out_n", ens_out_n, 35'h0);
        chk("rst_row_err_n", 35'(row_err_n), 35'h0);
        rst_n = 1'b1;
        cycles(5);

        // T1 / T6: straight frames on both polarities
        scan_frame(35'h0_0000_0505);
        chk("t1_scan_active", 35'(scan_active), 35'h1);
        chk("t1_scan_active_n", 35'(scan_active_n), 35'h1);
        chk("t1_ens_out_n", ens_out_n, 35'h0_0000_0505);
        scan_frame(35'h4_1234_5678);
        chk("t1_frames", 35'(frames_seen), 35'd2);

        // T2: 8-cycle glitch on row 2 must not complete a frame
        fs = frames_seen;
        scan_row(0, 7'h11, 100);
        scan_row(1, 7'h22, 100);
        scan_row(2, 7'h7F, 8);
        scan_row(3, 7'h44, 100);
        scan_row(4, 7'h08, 100);
        chk("t2_no_frame", 35'(frames_seen), 35'(fs));
        expect_frame({7'h08, 7'h44, 7'h33, 7'h22, 7'h11});
        scan_row(2, 7'h33, 100);
        chk("t2_frames", 35'(frames_seen), 35'(fs + 1));

        // T3: multi-hot row gives one row_err pulse and leaves seen intact
        fs = frames_seen;
        ep = err_pulses;
        scan_row(0, 7'h01, 100);
        scan_row(1, 7'h02, 100);
        row    = 5'b00011;
        column = 7'h7F;
        cycles(50);
        chk("t3_row_err_pulses", 35'(err_pulses), 35'(ep + 1));
        scan_row(2, 7'h04, 100);
        scan_row(3, 7'h08, 100);
        chk("t3_no_frame", 35'(frames_seen), 35'(fs));
        expect_frame({7'h10, 7'h08, 7'h04, 7'h02, 7'h01});
        scan_row(4, 7'h10, 100);
        chk("t3_frames", 35'(frames_seen), 35'(fs + 1));

        // T4: scanning stops; last capture was ~81 cycles before the blank starts
        row    = '0;
        column = '0;
        cycles(890);
        chk("t4_active_before", 35'(scan_active), 35'h1);
        cycles(150);
        chk("t4_active_after", 35'(scan_active), 35'h0);
        chk("t4_active_after_n", 35'(scan_active_n), 35'h0);
        chk("t4_ens_held", ens_out, last_frame);
        fs = frames_seen;
        scan_row(0, 7'h55, 100);
        scan_row(1, 7'h2A, 100);
        scan_row(2, 7'h7F, 100);
        chk("t4_partial_no_frame", 35'(frames_seen), 35'(fs));
        chk("t4_partial_inactive", 35'(scan_active), 35'h0);

        // T5: async reset mid-frame discards rows 0..2
        scan_row(0, 7'h03, 100);
        scan_row(1, 7'h06, 100);
        scan_row(2, 7'h0C, 100);
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        chk("t5_async_ens", ens_out, 35'h0);
        chk("t5_async_ens_n", ens_out_n, 35'h0);
        chk("t5_async_fv", 35'(frame_valid), 35'h0);
        chk("t5_async_active", 35'(scan_active), 35'h0);
        row    = '0;
        column = '0;
        cycles(3);
        rst_n = 1'b1;
        cycles(5);
        fs = frames_seen;
        scan_row(3, 7'h18, 100);
        scan_row(4, 7'h30, 100);
        scan_row(0, 7'h41, 100);
        scan_row(1, 7'h22, 100);
        chk("t5_no_frame", 35'(frames_seen), 35'(fs));
        expect_frame({7'h30, 7'h18, 7'h14, 7'h22, 7'h41});
        scan_row(2, 7'h14, 100);
        chk("t5_frames", 35'(frames_seen), 35'(fs + 1));

        row    = '0;
        column = '0;
        cycles(10);
        chk("end_exp_q_empty", 35'(exp_q.size()), 35'h0);
        chk("end_exp_n_q_empty", 35'(exp_n_q.size()), 35'h0);
        chk("end_frames_total", 35'(frames_seen), 35'd5);
        chk("end_frames_total_n", 35'(frames_seen_n), 35'd5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
